// File: rtl/mem_access_ctrl_if.sv
// Request-side and RAM-side bundles for mem_access_ctrl.
// Requester drives mem_req_if; controller drives mem_ram_if.
interface mem_req_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic              wr_req;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_req, wr_req, req_addr, req_wdata,
    input  busy, done, err, rd_data
  );

  modport slave (
    input  rd_req, wr_req, req_addr, req_wdata,
    output busy, done, err, rd_data
  );
endinterface

interface mem_ram_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-master load/store initiator for the 512x32 sync RAM.
// Strobes one cycle, waits MEM_LAT cycles for reads, pulses done.
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_req_if.slave  req,
  mem_ram_if.master ram
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic              is_rd_q, is_rd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      is_rd_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_rd_q <= is_rd_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_rd_d = is_rd_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          req.rd_req && req.wr_req: err_d = 1'b1;
          req.rd_req && !req.wr_req: begin
            addr_d  = req.req_addr;
            is_rd_d = 1'b1;
            state_d = ACCESS;
          end
          !req.rd_req && req.wr_req: begin
            addr_d  = req.req_addr;
            wdata_d = req.req_wdata;
            is_rd_d = 1'b0;
            state_d = ACCESS;
          end
          default: ;
        endcase
      end
      ACCESS: begin
        if (is_rd_q) begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        // capture on the edge the counter has run out
        if (cnt_q == 4'd0) begin
          rdata_d = ram.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  assign req.busy      = (state_q != IDLE);
  assign req.done      = (state_q == DONE);
  assign req.err       = err_q;
  assign req.rd_data   = rdata_q;
  assign ram.mem_read  = (state_q == ACCESS) && is_rd_q;
  assign ram.mem_write = (state_q == ACCESS) && !is_rd_q;
  assign ram.mem_addr  = addr_q;
  assign ram.mem_wdata = wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the 512x32 synchronous word RAM.
- Takes single load/store requests from datapath control and drives the RAM's Read/Write strobes, address and write data.
- Waits out the RAM's registered read latency, captures read data into an MDR-style holding register, and pulses completion.
- Sits between the control unit/MDR and the RAM; it is the only master of the RAM port.

Parameters:
- ADDR_W, 9, word-address width; 9 covers all 512 RAM words.
- DATA_W, 32, data word width.
- MEM_LAT, 1, cycles from the RAM sampling a read strobe to read data being capturable. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock shared with the RAM.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  1  load request; sampled only in IDLE.
- wr_req  in  1  store request; sampled only in IDLE.
- req_addr  in  ADDR_W  word address for the request.
- req_wdata  in  DATA_W  store data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on an illegal request.
- rd_data  out  DATA_W  captured load data; holds until the next load completes.
- mem_read  out  1  RAM Read strobe.
- mem_write  out  1  RAM Write strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, wait counter 0.
  - rd_data clears to 0.
  - Reset mid-operation drops mem_read/mem_write immediately, abandons the access, and emits no done.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE, request decoding at each rising edge:
  - rd_req=1, wr_req=0: latch req_addr into mem_addr; next state ACCESS (read).
  - wr_req=1, rd_req=0: latch req_addr into mem_addr and req_wdata into mem_wdata; next state ACCESS (write).
  - Both 1: no access, err=1 for exactly the next cycle, stay IDLE.
  - Neither: stay IDLE.
- ACCESS: lasts exactly 1 cycle.
  - mem_read=1 for a read, mem_write=1 for a write; never both.
  - Read goes to WAIT with counter loaded to MEM_LAT-1.
  - Write goes directly to DONE.
- WAIT (read only):
  - Strobes are 0.
  - Counter decrements each cycle.
  - On the edge where the counter is 0, mem_rdata is captured into rd_data and the FSM goes to DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- Request handling outside IDLE: requests arriving in ACCESS, WAIT or DONE are ignored, not queued. The requester must hold its request until busy=0.
- mem_addr and mem_wdata stay stable from the ACCESS cycle until the next accepted request.
- Latency, with edge E0 being the edge that samples the request in IDLE:
  - Write: mem_write high between E0 and E1; done high between E1 and E2.
  - Read: mem_read high between E0 and E1; rd_data valid and done high from edge E0+1+MEM_LAT for one cycle.
- Throughput: one read per 3+MEM_LAT cycles; one write per 3 cycles (IDLE, ACCESS, DONE).
- rd_data changes only on a read capture or on reset. Writes never disturb it.
- Address/data widths pass through without arithmetic. Every address 0..511 is legal.

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously; release with no requests -> busy=0, strobes stay 0 indefinitely.
- Write then read, MEM_LAT=1: write addr 0x05 data 0xDEADBEEF -> mem_write high 1 cycle with mem_addr=0x05, done 1 cycle later. Then read 0x05 -> mem_read high 1 cycle, rd_data=0xDEADBEEF and done=1 two edges after acceptance.
- Boundary addresses: write 0x000=0x00000001 and 0x1FF=0xFFFFFFFF, read both back -> exact values; no aliasing between 0x000 and 0x1FF.
- Illegal request: rd_req=wr_req=1 in IDLE -> err=1 for one cycle, mem_read=mem_write=0, rd_data unchanged, busy=0.
- Ignored and held requests: pulse wr_req during a read's WAIT -> ignored, no extra mem_write. Hold rd_req continuously -> back-to-back reads every 4 cycles (MEM_LAT=1).
- Reset mid-read: drop rst_n during WAIT -> strobes 0 immediately, no done pulse, rd_data=0. A subsequent read completes normally. Rerun the read test with MEM_LAT=3 -> done at edge E0+4.
